// File: rtl/core_pkg.sv
// Shared types and sizes for the RV32I execute-stage datapath.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NREGS);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLT  = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SRA  = 5'b01101,
    ALU_BEQ  = 5'b10000,
    ALU_BNE  = 5'b10001,
    ALU_BLT  = 5'b10100,
    ALU_BGE  = 5'b10101,
    ALU_BLTU = 5'b10110,
    ALU_BGEU = 5'b10111,
    ALU_PASS = 5'b11111
  } alu_op_e;

endpackage

// File: rtl/rf_alu_datapath_if.sv
// Control/data bundle between decode/control, data memory and the execute datapath.
// No handshake: every field is a level sampled combinationally or at the clock edge.
interface rf_alu_datapath_if;
  import core_pkg::*;

  logic [REG_ADDR_W-1:0] rs1_i;
  logic [REG_ADDR_W-1:0] rs2_i;
  logic [REG_ADDR_W-1:0] rd_i;
  logic                  regwrite_i;
  logic [XLEN-1:0]       imm_i;
  logic                  opBsel_i;
  logic [4:0]            aluc_i;
  logic [XLEN-1:0]       memdata_i;
  logic                  memtoreg_i;
  logic [XLEN-1:0]       operandA_o;
  logic [XLEN-1:0]       operandB_o;
  logic [XLEN-1:0]       alu_o;
  logic                  branch_o;
  logic [XLEN-1:0]       wd_o;

  modport master (
    output rs1_i, rs2_i, rd_i, regwrite_i, imm_i, opBsel_i, aluc_i, memdata_i, memtoreg_i,
    input  operandA_o, operandB_o, alu_o, branch_o, wd_o
  );

  modport slave (
    input  rs1_i, rs2_i, rd_i, regwrite_i, imm_i, opBsel_i, aluc_i, memdata_i, memtoreg_i,
    output operandA_o, operandB_o, alu_o, branch_o, wd_o
  );

endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU with branch compare; branch codes force the result to 0.
module alu
  import core_pkg::*;
(
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] c_o,
  output logic            branch_o
);

  alu_op_e    op;
  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign op    = alu_op_e'(op_i);
  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    c_o      = '0;
    branch_o = 1'b0;
    case (op)
      ALU_ADD:  c_o = a_i + b_i;
      ALU_SUB:  c_o = a_i - b_i;
      ALU_SLL:  c_o = a_i << shamt;
      ALU_SLT:  c_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: c_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  c_o = a_i ^ b_i;
      ALU_SRL:  c_o = a_i >> shamt;
      ALU_SRA:  c_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   c_o = a_i | b_i;
      ALU_AND:  c_o = a_i & b_i;
      ALU_PASS: c_o = a_i;
      ALU_BEQ:  branch_o = (a_i == b_i);
      ALU_BNE:  branch_o = (a_i != b_i);
      ALU_BLT:  branch_o = lt_s;
      ALU_BGE:  branch_o = ~lt_s;
      ALU_BLTU: branch_o = lt_u;
      ALU_BGEU: branch_o = ~lt_u;
      default: begin
        c_o      = '0;
        branch_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mux2.sv
// Two-input select of parameterised width: sel_i=0 picks a_i, sel_i=1 picks b_i.
module mux2 #(
  parameter int unsigned W = 32
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/regfile.sv
// 32-entry register file: two combinational read ports, one write port, x0 hardwired to 0.
module regfile
  import core_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  we_i,
  input  logic [XLEN-1:0]       wd_i,
  output logic [XLEN-1:0]       rd1_o,
  output logic [XLEN-1:0]       rd2_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i && (rd_i != '0)) begin
      regs_d[rd_i] = wd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Index 0 is decoded on the read side so x0 reads 0 regardless of storage contents.
  assign rd1_o = (rs1_i == '0) ? '0 : regs_q[rs1_i];
  assign rd2_o = (rs2_i == '0) ? '0 : regs_q[rs2_i];

endmodule

// File: rtl/rf_alu_datapath.sv
// Execute-stage slice: register file -> operand-B mux -> ALU -> write-back mux -> register file.
module rf_alu_datapath
  import core_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  rf_alu_datapath_if.slave   bus
);

  logic [XLEN-1:0] alu_b;

  regfile u_regfile (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rs1_i (bus.rs1_i),
    .rs2_i (bus.rs2_i),
    .rd_i  (bus.rd_i),
    .we_i  (bus.regwrite_i),
    .wd_i  (bus.wd_o),
    .rd1_o (bus.operandA_o),
    .rd2_o (bus.operandB_o)
  );

  mux2 #(.W(XLEN)) u_opb_mux (
    .sel_i (bus.opBsel_i),
    .a_i   (bus.operandB_o),
    .b_i   (bus.imm_i),
    .y_o   (alu_b)
  );

  alu u_alu (
    .op_i     (bus.aluc_i),
    .a_i      (bus.operandA_o),
    .b_i      (alu_b),
    .c_o      (bus.alu_o),
    .branch_o (bus.branch_o)
  );

  // The loop back into the register file is broken by the storage flops.
  mux2 #(.W(XLEN)) u_wb_mux (
    .sel_i (bus.memtoreg_i),
    .a_i   (bus.alu_o),
    .b_i   (bus.memdata_i),
    .y_o   (bus.wd_o)
  );

endmodule

// File: tb/tb_rf_alu_datapath.sv
// Bench for rf_alu_datapath: directed corner cases plus random traffic against a behavioural model.
module tb_rf_alu_datapath;

  logic clk;
  logic rst;

  rf_alu_datapath_if bus ();

  rf_alu_datapath dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] rf_m [32];
  logic [31:0] exp_q [$];
  int          n_total;
  int          n_bad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the instruction-set definitions.
  function automatic void ref_alu(input int unsigned op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic br);
    int unsigned sh;
    logic        lt_s;
    logic        lt_u;
    sh   = b % 32;
    lt_s = ($signed(a) < $signed(b));
    lt_u = (a < b);
    c    = 32'd0;
    br   = 1'b0;
    case (op)
      'h00: c = a + b;
      'h08: c = a - b;
      'h01: c = a << sh;
      'h02: c = lt_s ? 32'd1 : 32'd0;
      'h03: c = lt_u ? 32'd1 : 32'd0;
      'h04: c = a ^ b;
      'h05: c = a >> sh;
      'h0D: c = a[31] ? ~((~a) >> sh) : (a >> sh);
      'h06: c = a | b;
      'h07: c = a & b;
      'h1F: c = a;
      'h10: br = (a == b);
      'h11: br = (a != b);
      'h14: br = lt_s;
      'h15: br = !lt_s;
      'h16: br = lt_u;
      'h17: br = !lt_u;
      default: begin
        c  = 32'd0;
        br = 1'b0;
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs, optionally checks all outputs before the edge, then updates the model.
  task automatic step(input logic r, input int s1, input int s2, input int d, input logic we,
                      input logic [31:0] imm, input logic bsel, input int op,
                      input logic [31:0] mem, input logic m2r, input bit chk);
    logic [31:0] a, b2, b, c, wd;
    logic        br;
    @(negedge clk);
    rst            = r;
    bus.rs1_i      = 5'(s1);
    bus.rs2_i      = 5'(s2);
    bus.rd_i       = 5'(d);
    bus.regwrite_i = we;
    bus.imm_i      = imm;
    bus.opBsel_i   = bsel;
    bus.aluc_i     = 5'(op);
    bus.memdata_i  = mem;
    bus.memtoreg_i = m2r;
    #1;
    a  = (s1 == 0) ? 32'd0 : rf_m[s1];
    b2 = (s2 == 0) ? 32'd0 : rf_m[s2];
    b  = bsel ? imm : b2;
    ref_alu(op, a, b, c, br);
    wd = m2r ? mem : c;
    if (chk) begin
      exp_q.push_back(a);
      exp_q.push_back(b2);
      exp_q.push_back(c);
      exp_q.push_back({31'd0, br});
      exp_q.push_back(wd);
      check_eq("operandA", bus.operandA_o, exp_q.pop_front());
      check_eq("operandB", bus.operandB_o, exp_q.pop_front());
      check_eq("alu",      bus.alu_o,      exp_q.pop_front());
      check_eq("branch",   {31'd0, bus.branch_o}, exp_q.pop_front());
      check_eq("wd",       bus.wd_o,       exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    end else if (we && d != 0) begin
      rf_m[d] = wd;
    end
  endtask

  int ops [17] = '{'h00, 'h08, 'h01, 'h02, 'h03, 'h04, 'h05, 'h0D, 'h06, 'h07, 'h1F,
                   'h10, 'h11, 'h14, 'h15, 'h16, 'h17};

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    rst            = 1'b1;
    bus.rs1_i      = '0;
    bus.rs2_i      = '0;
    bus.rd_i       = '0;
    bus.regwrite_i = 1'b0;
    bus.imm_i      = '0;
    bus.opBsel_i   = 1'b0;
    bus.aluc_i     = '0;
    bus.memdata_i  = '0;
    bus.memtoreg_i = 1'b0;

    // Reset for one edge, then every index must read 0.
    step(1, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, i, 31 - i, 0, 0, 0, 0, 'h00, 0, 0, 1);
      check_eq("rst_rdA", bus.operandA_o, 32'd0);
    end

    // x1 = 0 + 5, then x1 - x1.
    step(0, 0, 0, 1, 1, 32'd5, 1, 'h00, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0, 'h08, 0, 0, 1);
    check_eq("x1_val", bus.operandA_o, 32'd5);
    check_eq("sub_zero", bus.alu_o, 32'd0);

    // Writes to x0 are dropped.
    step(0, 0, 0, 0, 1, 0, 0, 'h00, 32'hDEADBEEF, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 1);
    check_eq("x0_zero", bus.operandA_o, 32'd0);

    // Shifts on x2 = 0x80000000.
    step(0, 0, 0, 2, 1, 0, 0, 'h00, 32'h80000000, 1, 1);
    step(0, 2, 0, 0, 0, 32'd4, 1, 'h0D, 0, 0, 1);
    check_eq("sra", bus.alu_o, 32'hF8000000);
    step(0, 2, 0, 0, 0, 32'd4, 1, 'h05, 0, 0, 1);
    check_eq("srl", bus.alu_o, 32'h08000000);
    step(0, 1, 0, 0, 0, 32'h21, 1, 'h01, 0, 0, 1);
    check_eq("sll_mask", bus.alu_o, 32'd10);

    // Compares with x4 = 0xFFFFFFFF against 1.
    step(0, 0, 0, 4, 1, 0, 0, 'h00, 32'hFFFFFFFF, 1, 1);
    step(0, 4, 0, 0, 0, 32'd1, 1, 'h02, 0, 0, 1);
    check_eq("slt", bus.alu_o, 32'd1);
    step(0, 4, 0, 0, 0, 32'd1, 1, 'h03, 0, 0, 1);
    check_eq("sltu", bus.alu_o, 32'd0);
    step(0, 4, 0, 0, 0, 32'd1, 1, 'h14, 0, 0, 1);
    check_eq("blt", {31'd0, bus.branch_o}, 32'd1);
    step(0, 4, 0, 0, 0, 32'd1, 1, 'h16, 0, 0, 1);
    check_eq("bltu", {31'd0, bus.branch_o}, 32'd0);
    step(0, 4, 4, 0, 0, 0, 0, 'h10, 0, 0, 1);
    check_eq("beq_br", {31'd0, bus.branch_o}, 32'd1);
    check_eq("beq_c", bus.alu_o, 32'd0);

    // Load write-back, then reset beats a simultaneous write.
    step(0, 0, 0, 3, 1, 0, 0, 'h00, 32'h1234, 1, 1);
    step(0, 3, 0, 0, 0, 0, 0, 'h00, 0, 0, 1);
    check_eq("x3_load", bus.operandA_o, 32'h1234);
    step(1, 3, 0, 3, 1, 0, 0, 'h00, 32'h5678, 1, 1);
    step(0, 3, 0, 0, 0, 0, 0, 'h00, 0, 0, 1);
    check_eq("x3_rst", bus.operandA_o, 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int          op;
      logic [31:0] imm;
      op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : ops[$urandom_range(0, 16)];
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), 1'($urandom_range(0, 1)), imm, 1'($urandom_range(0, 1)),
           op, $urandom, 1'($urandom_range(0, 3) == 0), 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
